div_iter_unit: RTL

- Iterative signed 32-bit restoring divider datapath for the CPU's multdiv unit.
- Accepts a ctrl_DIV start pulse and latches the operands.
- Produces one quotient bit per cycle using shift/subtract and an internal iteration counter.
- Raises data_resultRDY exactly 33 cycles after the start cycle; the pipeline stall logic consumes it.

---
 rtl/div_pkg.sv | 13 +
 rtl/div_iter_counter.sv | 26 ++
 rtl/div_iter_unit.sv | 106 ++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared constants and FSM encoding for the iterative signed divider.
// DONE_COUNT is the iteration-counter value that marks a completed division.
package div_pkg;
  localparam int WIDTH      = 32;
  localparam int DONE_COUNT = WIDTH + 1;
  localparam int CNT_W      = $clog2(DONE_COUNT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter: synchronous active-low clear, count enable, done flag at DONE_COUNT.
// Single-cycle update; no backpressure, the counter simply holds when not enabled.
module div_iter_counter
  import div_pkg::*;
(
  input  logic             clock,
  input  logic             i_clr_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (!i_clr_n) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_done = (r_cnt == CNT_W'(DONE_COUNT));

endmodule

// File: rtl/div_iter_unit.sv
// Iterative signed restoring divider: one quotient bit per cycle on operand magnitudes.
// Result pulse 33 cycles after start; a new start at any time aborts the division in flight.
module div_iter_unit
  import div_pkg::*;
(
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DONE_COUNT - 2);

  state_t           r_state, w_state_nxt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo, r_dvs, r_result;
  logic             r_neg_q, r_divzero, r_exc;

  logic [CNT_W-1:0] w_cnt;
  logic             w_cnt_done, w_cnt_clr_n, w_cnt_en, w_last;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_quo_nxt, w_quo_fix;
  logic [WIDTH:0]   w_rem_sh, w_diff, w_rem_nxt;
  logic             w_fits;

  div_iter_counter u_cnt (
    .clock   (clock),
    .i_clr_n (w_cnt_clr_n),
    .i_en    (w_cnt_en),
    .o_cnt   (w_cnt),
    .o_done  (w_cnt_done)
  );

  assign w_cnt_clr_n = ctrl_reset & ~ctrl_DIV;
  assign w_cnt_en    = (r_state != IDLE) & ~w_cnt_done;
  assign w_last      = (r_state == RUN) && (w_cnt == LAST_ITER);

  assign w_abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  // True shifted remainder is {r_rem, quo msb}; its top bit alone guarantees it exceeds the divisor.
  assign w_rem_sh  = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_fits    = r_rem[WIDTH] | (w_rem_sh >= {1'b0, r_dvs});
  assign w_diff    = w_rem_sh - {1'b0, r_dvs};
  assign w_rem_nxt = w_fits ? w_diff : w_rem_sh;
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_fits};
  assign w_quo_fix = r_divzero ? '0 : (r_neg_q ? -w_quo_nxt : w_quo_nxt);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (ctrl_DIV) w_state_nxt = RUN;
      RUN: begin
        if (ctrl_DIV)    w_state_nxt = RUN;
        else if (w_last) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = ctrl_DIV ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvs     <= '0;
      r_neg_q   <= 1'b0;
      r_divzero <= 1'b0;
      r_result  <= '0;
      r_exc     <= 1'b0;
    end else if (ctrl_DIV) begin
      r_rem     <= '0;
      r_quo     <= w_abs_a;
      r_dvs     <= w_abs_b;
      r_neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      r_divzero <= (data_operandB == '0);
      r_result  <= '0;
      r_exc     <= 1'b0;
    end else if (r_state == RUN) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      if (w_last) begin
        r_result <= w_quo_fix;
        r_exc    <= r_divzero;
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = (r_state == DONE);
  assign busy           = (r_state == RUN);

endmodule
